// File: rtl/sram_pkg.sv
// Shared definitions for the 1 KB x 8 SRAM controller.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_DEPTH : default array geometry
//   sram_ctrl_state_t                      : controller FSM states
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 8;
  localparam int unsigned SRAM_DEPTH  = 1 << SRAM_ADDR_W;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StWrite,
    StRead
  } sram_ctrl_state_t;

endpackage

// File: rtl/sram_tristate_buf.sv
// Tri-state pad driver for the shared SRAM data bus.
// Ports:
//   oe   : drive enable; pad is high-impedance when low
//   dout : value driven onto the pad
//   din  : value currently on the pad
//   pad  : bidirectional bus
module sram_tristate_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             oe,
  input  logic [Width-1:0] dout,
  output logic [Width-1:0] din,
  inout  wire  [Width-1:0] pad
);

  assign pad = oe ? dout : {Width{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl_8bit_1024.sv
// Initiator-side controller for a single-port SRAM with a shared tri-state data bus.
// Single-byte read/write requests arrive over a valid/ready handshake; each access takes
// one strobe cycle followed by a return to idle. Read data is registered into rsp_rdata
// and flagged by a one-cycle rsp_valid pulse.
// Optional feature macro: SRAM_INIT_CLEAR_EN -- when defined, every reset zero-fills the
// array with CLEAR_VALUE before init_done rises.
// Ports:
//   clk, reset_n                         : clock, async active-low reset
//   req_valid/req_ready/req_wr/req_addr/req_wdata : client request channel
//   rsp_valid, rsp_rdata                 : read response (no backpressure)
//   init_done                            : requests may be accepted
//   mem_wr_en, mem_rd_en, mem_addr       : SRAM strobes and address
//   mem_data                             : SRAM bidirectional data bus
module sram_ctrl_8bit_1024
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned       DATA_W      = SRAM_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

`ifdef SRAM_INIT_CLEAR_EN
  localparam sram_ctrl_state_t ResetState = StClear;
`else
  localparam sram_ctrl_state_t ResetState = StIdle;
`endif

  sram_ctrl_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_valid_q;
  logic              init_done_q, init_done_d;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_dout;
  logic [DATA_W-1:0] bus_din;

`ifdef SRAM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_last;

  assign clr_last  = (clr_cnt_q == {ADDR_W{1'b1}});
  // Saturates at the last address; a fresh reset restarts it from zero.
  assign clr_cnt_d = ((state_q == StClear) && !clr_last) ? clr_cnt_q + 1'b1 : clr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ResetState;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= (state_q == StRead);
      if (state_q == StRead) begin
        rdata_q <= bus_din;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef SRAM_INIT_CLEAR_EN
    init_done_d = init_done_q;
`else
    // Without the clear pass the array is usable from the first edge after reset.
    init_done_d = 1'b1;
`endif
    case (state_q)
      StClear: begin
`ifdef SRAM_INIT_CLEAR_EN
        if (clr_last) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StIdle: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_wr ? StWrite : StRead;
        end
      end
      StWrite: state_d = StIdle;
      StRead:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes come only from registered state, so req_* never reaches mem_* combinationally.
  assign req_ready = (state_q == StIdle) && init_done_q;
  assign mem_rd_en = (state_q == StRead);

`ifdef SRAM_INIT_CLEAR_EN
  // The state register already holds StClear while reset is asserted; gating with reset_n
  // keeps the write strobe and bus released until reset is removed.
  assign mem_wr_en = (state_q == StWrite) || ((state_q == StClear) && reset_n);
  assign mem_addr  = (state_q == StClear) ? clr_cnt_q : addr_q;
  assign bus_dout  = (state_q == StClear) ? CLEAR_VALUE : wdata_q;
`else
  assign mem_wr_en = (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign bus_dout  = wdata_q;
`endif

  // The bus is driven exactly when writing; never while mem_rd_en is high.
  assign bus_oe    = mem_wr_en;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign init_done = init_done_q;

  sram_tristate_buf #(
    .Width(DATA_W)
  ) u_tristate (
    .oe  (bus_oe),
    .dout(bus_dout),
    .din (bus_din),
    .pad (mem_data)
  );

endmodule

// File: tb/tb_sram_ctrl_8bit_1024.sv
// Self-checking bench for sram_ctrl_8bit_1024 with an attached behavioural SRAM.
// Works with or without SRAM_INIT_CLEAR_EN defined.
module tb_sram_ctrl_8bit_1024;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;
  localparam logic [7:0]  CLR   = 8'h00;
`ifdef SRAM_INIT_CLEAR_EN
  localparam bit ClearOn = 1'b1;
  localparam int InitLat = DEPTH;
`else
  localparam bit ClearOn = 1'b0;
  localparam int InitLat = 1;
`endif

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  int n_tests;
  int n_fail;

  sram_ctrl_8bit_1024 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus only while output-enabled, captures on write strobe.
  logic [DW-1:0] sram [DEPTH];
  assign mem_data = mem_rd_en ? sram[mem_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Reference model: edges since reset release, the access (if any) occupying this cycle,
  // the pending response and the expected array contents.
  int            rel;
  bit            acc_act, acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  bit            rsp_now;
  logic [DW-1:0] rdata_m;
  bit            rdata_known;
  logic [DW-1:0] mem_m [DEPTH];
  bit            known [DEPTH];

  initial begin
    bit clr_act, idone, rdy, wr_e, rd_e;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    rel = 0; acc_act = 0; rsp_now = 0; rdata_m = '0; rdata_known = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_bus_oe", dut.u_tristate.oe, 0);
        if (acc_act && acc_wr) known[acc_addr] = 1'b0;
        rel = 0; acc_act = 0; rsp_now = 0; rdata_m = '0; rdata_known = 1'b1;
      end else begin
        clr_act = ClearOn && (rel < DEPTH);
        idone   = (rel >= InitLat);
        rdy     = idone && !acc_act && !clr_act;
        wr_e    = clr_act || (acc_act && acc_wr);
        rd_e    = acc_act && !acc_wr;
        check("m_req_ready", req_ready, rdy);
        check("m_init_done", init_done, idone);
        check("m_wr_en", mem_wr_en, wr_e);
        check("m_rd_en", mem_rd_en, rd_e);
        check("m_bus_oe", dut.u_tristate.oe, wr_e);
        check("m_rsp_valid", rsp_valid, rsp_now);
        if (rdata_known) check("m_rsp_rdata", rsp_rdata, rdata_m);
        if (wr_e) begin
          check("m_wr_addr", mem_addr, clr_act ? rel[AW-1:0] : acc_addr);
          check("m_wr_data", mem_data, clr_act ? CLR : acc_data);
        end
        if (rd_e) check("m_rd_addr", mem_addr, acc_addr);
        // Advance to the next cycle.
        if (acc_act && acc_wr) begin
          mem_m[acc_addr] = acc_data;
          known[acc_addr] = 1'b1;
        end
        rsp_now = acc_act && !acc_wr;
        if (rsp_now) begin
          rdata_m     = mem_m[acc_addr];
          rdata_known = known[acc_addr];
        end
        if (clr_act && rel == DEPTH - 1) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = CLR;
            known[i] = 1'b1;
          end
        end
        acc_act = rdy && req_valid;
        if (acc_act) begin
          acc_wr   = req_wr;
          acc_addr = req_addr;
          acc_data = req_wdata;
        end
        if (rel < 100000) rel++;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after a rising edge.
  int cyc;
  int done_at;
  int acc_edge;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n;
    bit ok;
    req_wr = wr; req_addr = addr; req_wdata = data; req_valid = 1'b1;
    ok = 0;
    for (n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: got no acceptance, expected acceptance in 3000 cycles");
    end
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp);
    do_req(1'b0, addr, '0);
    @(negedge clk);
    check({name, "_rd_en"}, mem_rd_en, 1);
    tick();
    check({name, "_rsp_valid"}, rsp_valid, 1);
    check({name, "_rdata"}, rsp_rdata, exp);
  endtask

  task automatic obs_cycle(output bit acc);
    @(negedge clk);
    if (init_done && done_at < 0) done_at = cyc;
    acc = req_valid && req_ready;
    tick();
    cyc++;
  endtask

  task automatic wait_init();
    int n;
    for (n = 0; n < 3000 && !init_done; n++) tick();
    check("wait_init_done", init_done, 1);
  endtask

  logic [AW-1:0] t_addr [4] = '{10'h3FF, 10'h000, 10'h2AA, 10'h155};
  logic [DW-1:0] t_data [4] = '{8'hFF, 8'h01, 8'h55, 8'hAA};

  initial begin
    bit acc;
    logic [DW-1:0] exp_v;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    check("lit_rst_init_done", init_done, 0);
    check("lit_rst_rsp_rdata", rsp_rdata, 0);

    // Reset release, init latency and a request raised 5 cycles in.
    reset_n = 1'b1;
    cyc = 0; done_at = -1; acc = 0;
    repeat (5) obs_cycle(acc);
    req_wr = 1'b0; req_addr = 10'h3FF; req_wdata = '0; req_valid = 1'b1;
    acc = 0;
    while (!acc && cyc < 3000) obs_cycle(acc);
    acc_edge = cyc;
    req_valid = 1'b0;
    check("init_latency", done_at, InitLat);
    check("accept_edge", acc_edge, ((InitLat > 5) ? InitLat : 5) + 1);
    tick();
    check("first_rsp_valid", rsp_valid, 1);
`ifdef SRAM_INIT_CLEAR_EN
    check("cleared_3ff", rsp_rdata, 8'h00);
`endif

    // Single write then read.
    do_req(1'b1, 10'h005, 8'h3A);
    read_check("wr_rd_005", 10'h005, 8'h3A);

    // Read followed by a held write to the same address: turnaround cycle.
    do_req(1'b0, 10'h010, '0);
    req_wr = 1'b1; req_addr = 10'h010; req_wdata = 8'hC5; req_valid = 1'b1;
    @(negedge clk);
    check("ta_read_cycle_rd", mem_rd_en, 1);
    check("ta_read_cycle_ready", req_ready, 0);
    tick();
    check("ta_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    check("ta_gap_strobes", {mem_wr_en, mem_rd_en}, 2'b00);
    check("ta_gap_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("ta_write_strobe", mem_wr_en, 1);
    check("ta_write_bus", mem_data, 8'hC5);
    tick();
    read_check("ta_reread", 10'h010, 8'hC5);

    // Boundary and pattern writes, then read back.
    for (int i = 0; i < 4; i++) do_req(1'b1, t_addr[i], t_data[i]);
    for (int i = 0; i < 4; i++) read_check("pattern", t_addr[i], t_data[i]);

    // Reset in the middle of a write.
    do_req(1'b1, 10'h020, 8'h77);
    check("mid_wr_active", mem_wr_en, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr_en", mem_wr_en, 0);
    check("mid_rst_bus_oe", dut.u_tristate.oe, 0);
    check("mid_rst_init_done", init_done, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    @(negedge clk);
`ifdef SRAM_INIT_CLEAR_EN
    check("restart_clear_wr", mem_wr_en, 1);
    check("restart_clear_addr", mem_addr, 10'h000);
    exp_v = 8'h00;
`else
    check("restart_no_clear_wr", mem_wr_en, 0);
    check("restart_init_low", init_done, 0);
    exp_v = 8'hFF;
`endif
    tick();
    wait_init();
    read_check("post_reset_3ff", 10'h3FF, exp_v);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
